// File: rtl/uart_rx_param_if.sv
// Receiver-to-consumer bus: received word, error flags, overrun pulse and valid/ready handshake.
// The receiver drives through the master modport and the consumer through the slave modport.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, oversampled 3-sample majority vote,
// configurable data/parity/stop framing, and a valid/ready output with overrun detection.
module uart_rx_param #(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_i,
  output logic            busy_o,
  uart_rx_param_if.master rx_if
);

  localparam int unsigned DIV_RAW  = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned TICK_DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned S_W      = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W    = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [S_W-1:0]    S_MID_M1  = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0]    S_MID     = S_W'(OVERSAMPLE / 2);
  localparam logic [S_W-1:0]    S_MID_P1  = S_W'(OVERSAMPLE / 2 + 1);
  localparam logic [S_W-1:0]    S_LAST    = S_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8) begin : g_bad_oversample
    $error("uart_rx_param: OVERSAMPLE must be even and >= 8");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            sync_q;
  logic [TICK_W-1:0]     tick_q;
  logic [S_W-1:0]        s_q, s_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  stop_q, stop_d;
  logic [1:0]            smp_q, smp_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  perr_pend_q, perr_pend_d;
  logic                  ferr_pend_q, ferr_pend_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  busy_q, busy_d;

  logic rxs;
  logic tick;
  logic maj;
  logic parity_bad;
  logic commit;
  logic accept;

  assign rxs  = sync_q[1];
  assign tick = (tick_q == TICK_LAST);
  // The third vote is the live synchronised sample, taken at S_MID_P1.
  assign maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
  assign parity_bad = (PARITY == 1) ? ~((^shift_q) ^ maj) : ((^shift_q) ^ maj);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      tick_q <= '0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      tick_q <= tick ? '0 : tick_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    smp_d       = smp_q;
    shift_d     = shift_q;
    perr_pend_d = perr_pend_q;
    ferr_pend_d = ferr_pend_q;
    commit      = 1'b0;
    if (tick) begin
      if (state_q != ST_IDLE) begin
        s_d = (s_q == S_LAST) ? '0 : s_q + 1'b1;
        if (s_q == S_MID_M1) smp_d[0] = rxs;
        if (s_q == S_MID)    smp_d[1] = rxs;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (!rxs) begin
            state_d     = ST_START;
            s_d         = '0;
            bit_d       = '0;
            stop_d      = 1'b0;
            perr_pend_d = 1'b0;
            ferr_pend_d = 1'b0;
          end
        end
        ST_START: begin
          if (s_q == S_MID_P1 && maj) state_d = ST_IDLE;
          else if (s_q == S_LAST)     state_d = ST_DATA;
        end
        ST_DATA: begin
          if (s_q == S_MID_P1) shift_d = {maj, shift_q[DATA_BITS-1:1]};
          if (s_q == S_LAST) begin
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (s_q == S_MID_P1) perr_pend_d = parity_bad;
          if (s_q == S_LAST)   state_d = ST_STOP;
        end
        ST_STOP: begin
          // Final stop commits at mid-bit so the next start edge is caught promptly.
          if (s_q == S_MID_P1) begin
            if (!maj) ferr_pend_d = 1'b1;
            if (stop_q == STOP_LAST) begin
              commit  = 1'b1;
              state_d = ST_IDLE;
              s_d     = '0;
            end
          end else if (s_q == S_LAST) begin
            stop_d = stop_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    accept  = valid_q && rx_if.rx_ready;
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = 1'b0;
    if (accept) valid_d = 1'b0;
    if (commit) begin
      if (!valid_q || accept) begin
        data_d  = shift_q;
        perr_d  = perr_pend_q;
        ferr_d  = ferr_pend_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      smp_q       <= '0;
      shift_q     <= '0;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      bit_q       <= bit_d;
      stop_q      <= stop_d;
      smp_q       <= smp_d;
      shift_q     <= shift_d;
      perr_pend_q <= perr_pend_d;
      ferr_pend_q <= ferr_pend_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_if.rx_data    = data_q;
  assign rx_if.rx_valid   = valid_q;
  assign rx_if.parity_err = perr_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.overrun    = ovr_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 8E1, 9O2) at 16 clk per bit,
// directed scenarios plus random frames checked against a frame-level reference.
module tb_uart_rx_param;
  logic clk = 1'b0;
  logic rst;
  logic rx_a, rx_b, rx_c;
  logic busy_a, busy_b, busy_c;

  int passed = 0;
  int total  = 0;

  uart_rx_param_if #(.DATA_BITS(8)) a_if ();
  uart_rx_param_if #(.DATA_BITS(8)) b_if ();
  uart_rx_param_if #(.DATA_BITS(9)) c_if ();

  uart_rx_param #(.CLOCK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u_a (.clk(clk), .rst(rst), .rx_i(rx_a), .busy_o(busy_a), .rx_if(a_if.master));
  uart_rx_param #(.CLOCK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    u_b (.clk(clk), .rst(rst), .rx_i(rx_b), .busy_o(busy_b), .rx_if(b_if.master));
  uart_rx_param #(.CLOCK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                  .DATA_BITS(9), .PARITY(1), .STOP_BITS(2))
    u_c (.clk(clk), .rst(rst), .rx_i(rx_c), .busy_o(busy_c), .rx_if(c_if.master));

  always #5 clk = ~clk;

  // Delivered frames, packed as {frame_err, parity_err, data[8:0]}.
  logic [10:0] cap_a[$];
  logic [10:0] cap_b[$];
  logic [10:0] cap_c[$];
  int run_a = 0, last_run_a = 0, ovr_cnt_a = 0;

  always @(negedge clk) begin
    if (a_if.rx_valid && a_if.rx_ready)
      cap_a.push_back({a_if.frame_err, a_if.parity_err, 1'b0, a_if.rx_data});
    if (b_if.rx_valid && b_if.rx_ready)
      cap_b.push_back({b_if.frame_err, b_if.parity_err, 1'b0, b_if.rx_data});
    if (c_if.rx_valid && c_if.rx_ready)
      cap_c.push_back({c_if.frame_err, c_if.parity_err, c_if.rx_data});
    if (a_if.overrun) ovr_cnt_a <= ovr_cnt_a + 1;
    if (a_if.rx_valid) run_a <= run_a + 1;
    else begin
      if (run_a != 0) last_run_a <= run_a;
      run_a <= 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input int which, input logic v);
    case (which)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // glitch_bit >= 0 inverts the line for one clk near the middle of that data bit.
  task automatic send_frame(input int which, input logic [8:0] word, input int nbits,
                            input bit has_par, input logic par, input int nstop,
                            input bit stop_low, input int glitch_bit, input int gap);
    logic [13:0] lv;
    int n;
    n = 0;
    lv = '1;
    lv[n] = 1'b0; n++;
    for (int i = 0; i < nbits; i++) begin lv[n] = word[i]; n++; end
    if (has_par) begin lv[n] = par; n++; end
    for (int i = 0; i < nstop; i++) begin lv[n] = ~stop_low; n++; end
    for (int b = 0; b < n; b++) begin
      set_rx(which, lv[b]);
      for (int c = 0; c < 16; c++) begin
        if (glitch_bit >= 0 && b == glitch_bit + 1 && c == 10) set_rx(which, ~lv[b]);
        if (glitch_bit >= 0 && b == glitch_bit + 1 && c == 11) set_rx(which, lv[b]);
        tick(1);
      end
    end
    set_rx(which, 1'b1);
    tick(gap);
  endtask

  function automatic int cap_size(input int which);
    case (which)
      0: return cap_a.size();
      1: return cap_b.size();
      default: return cap_c.size();
    endcase
  endfunction

  task automatic expect_frame(input int which, input string tag, input logic [8:0] d,
                              input logic pe, input logic fe);
    logic [10:0] got;
    int waited;
    bit have;
    waited = 0;
    have = (cap_size(which) > 0);
    while (!have && waited < 48) begin
      tick(1);
      waited++;
      have = (cap_size(which) > 0);
    end
    check({tag, "_arrived"}, 32'(have), 32'd1);
    if (have) begin
      case (which)
        0: got = cap_a.pop_front();
        1: got = cap_b.pop_front();
        default: got = cap_c.pop_front();
      endcase
      check({tag, "_data"}, 32'(got[8:0]), 32'(d));
      check({tag, "_parity_err"}, 32'(got[9]), 32'(pe));
      check({tag, "_frame_err"}, 32'(got[10]), 32'(fe));
    end
  endtask

  initial begin
    logic [8:0] d;
    logic p, sl, bad;
    int base_ovr, busy_cycles;
    logic [8:0] w6;

    rst = 1'b1;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    a_if.rx_ready = 1'b1;
    b_if.rx_ready = 1'b1;
    c_if.rx_ready = 1'b1;
    tick(3);
    check("reset_a", {a_if.rx_data, a_if.rx_valid, a_if.parity_err, a_if.frame_err,
                      a_if.overrun, busy_a}, '0);
    check("reset_b", {b_if.rx_data, b_if.rx_valid, b_if.parity_err, b_if.frame_err,
                      b_if.overrun, busy_b}, '0);
    check("reset_c", {c_if.rx_data, c_if.rx_valid, c_if.parity_err, c_if.frame_err,
                      c_if.overrun, busy_c}, '0);
    rst = 1'b0;
    tick(20);

    // 8N1 with a one-clk glitch on data bit 3
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 0, 3, 4);
    expect_frame(0, "t1_glitch", 9'h0A5, 1'b0, 1'b0);
    tick(2);
    check("t1_valid_width", 32'(last_run_a), 32'd1);

    // even parity: wrong then right parity bit
    send_frame(1, 9'h007, 8, 1, 1'b0, 1, 0, -1, 4);
    expect_frame(1, "t2_bad_par", 9'h007, 1'b1, 1'b0);
    send_frame(1, 9'h007, 8, 1, 1'b1, 1, 0, -1, 4);
    expect_frame(1, "t2_good_par", 9'h007, 1'b0, 1'b0);

    // low stop bit, then a clean frame
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 1, -1, 32);
    expect_frame(0, "t3_low_stop", 9'h03C, 1'b0, 1'b1);
    send_frame(0, 9'h055, 8, 0, 1'b0, 1, 0, -1, 4);
    expect_frame(0, "t3_clean", 9'h055, 1'b0, 1'b0);
    tick(4);

    // 4-clk low pulse must be rejected as a false start
    busy_cycles = 0;
    set_rx(0, 1'b0);
    for (int c = 0; c < 32; c++) begin
      if (c == 4) set_rx(0, 1'b1);
      busy_cycles += int'(busy_a);
      tick(1);
    end
    check("t4_busy_bounded", 32'(busy_cycles > 0 && busy_cycles <= 16), 32'd1);
    check("t4_busy_low", 32'(busy_a), 32'd0);
    check("t4_no_valid", 32'(a_if.rx_valid), 32'd0);
    check("t4_no_frame", 32'(cap_a.size()), 32'd0);
    check("t4_data_kept", 32'(a_if.rx_data), 32'h55);

    // back-to-back frames with consumer stalled -> overrun on the second
    a_if.rx_ready = 1'b0;
    base_ovr = ovr_cnt_a;
    send_frame(0, 9'h011, 8, 0, 1'b0, 1, 0, -1, 0);
    send_frame(0, 9'h022, 8, 0, 1'b0, 1, 0, -1, 4);
    check("t5_overrun_pulses", 32'(ovr_cnt_a - base_ovr), 32'd1);
    check("t5_overrun_low", 32'(a_if.overrun), 32'd0);
    check("t5_data_held", 32'(a_if.rx_data), 32'h11);
    check("t5_valid_held", 32'(a_if.rx_valid), 32'd1);
    a_if.rx_ready = 1'b1;
    expect_frame(0, "t5_accept", 9'h011, 1'b0, 1'b0);
    tick(2);
    check("t5_valid_dropped", 32'(a_if.rx_valid), 32'd0);
    check("t5_second_dropped", 32'(cap_a.size()), 32'd0);

    // 9O2: reset asserted in the middle of data bit 4
    w6 = 9'h1AB;
    set_rx(2, 1'b0);
    tick(16);
    for (int i = 0; i < 4; i++) begin
      set_rx(2, w6[i]);
      tick(16);
    end
    set_rx(2, w6[4]);
    tick(8);
    rst = 1'b1;
    tick(2);
    check("t6_rst_outputs", {c_if.rx_data, c_if.rx_valid, c_if.parity_err, c_if.frame_err,
                             c_if.overrun, busy_c}, '0);
    set_rx(2, 1'b1);
    tick(2);
    rst = 1'b0;
    tick(40);
    check("t6_no_partial", 32'(cap_c.size()), 32'd0);
    check("t6_valid_low", 32'(c_if.rx_valid), 32'd0);
    send_frame(2, w6, 9, 1, 1'b1, 2, 0, -1, 4);
    expect_frame(2, "t6_after_rst", 9'h1AB, 1'b0, 1'b0);

    // random 8N1 frames, occasional low stop bit
    for (int k = 0; k < 10; k++) begin
      d  = 9'($urandom_range(0, 255));
      sl = ($urandom_range(0, 3) == 0);
      send_frame(0, d, 8, 0, 1'b0, 1, sl, -1, sl ? 32 : 0);
      expect_frame(0, "rand_a", d, 1'b0, sl);
    end

    // random 8E1 frames: correct even parity bit is XOR of data; sometimes flipped
    for (int k = 0; k < 10; k++) begin
      d   = 9'($urandom_range(0, 255));
      bad = ($urandom_range(0, 2) == 0);
      p   = (^d) ^ bad;
      send_frame(1, d, 8, 1, p, 1, 0, -1, 0);
      expect_frame(1, "rand_b", d, (^d) ^ p, 1'b0);
    end

    // random 9O2 frames: odd parity error when XOR(data)^p == 0
    for (int k = 0; k < 8; k++) begin
      d   = 9'($urandom_range(0, 511));
      bad = ($urandom_range(0, 2) == 0);
      sl  = ($urandom_range(0, 4) == 0);
      p   = ~(^d) ^ bad;
      send_frame(2, d, 9, 1, p, 2, sl, -1, sl ? 32 : 0);
      expect_frame(2, "rand_c", d, ((^d) ^ p) == 1'b0, sl);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver. It is the successor to the team's fixed 8N1 receiver and adds:
- configurable data width, parity and stop bits
- an input synchroniser
- 16x oversampling with 3-sample majority vote
- false-start rejection
- parity and framing error flags
- a valid/ready output handshake with overrun detection

It sits between the board RX pin and the command/byte-stream consumer logic.

Parameters:
CLOCK_FREQ, 100_000_000, system clock frequency in Hz.
BAUD_RATE, 9600, line baud rate.
OVERSAMPLE, 16, samples per bit; must be even and >= 8.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
rx  input  1  asynchronous serial line; idles high.
rx_data  output  DATA_BITS  received word, LSB = first bit on the wire.
rx_valid  output  1  rx_data and flags hold a frame.
rx_ready  input  1  consumer accepts the frame when rx_valid && rx_ready.
parity_err  output  1  parity mismatch for the current rx_data; 0 when PARITY = 0.
frame_err  output  1  a stop bit was sampled low for the current rx_data.
overrun  output  1  one-cycle pulse: a completed frame was dropped.
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, active-high):
  - rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0.
  - Both synchroniser flops = 1. FSM = IDLE. All counters = 0.
- rx passes through a 2-flop synchroniser. All logic below uses the synchronised value (rxs).
- Tick generator: free-running counter 0..TICK_DIV-1, with TICK_DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE), integer division, minimum 1. It emits a 1-clk tick at terminal count.
- Sample counter s runs 0..OVERSAMPLE-1 and advances on each tick.
- Bit value = majority of rxs captured at s = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- FSM states and transitions:
  - IDLE: on a tick with rxs = 0, set s = 0 and go to START.
  - START: at s = OVERSAMPLE/2+1, if the majority is 1 this is a false start: return to IDLE with no output change. Otherwise, at s = OVERSAMPLE-1, go to DATA.
  - DATA: shift in DATA_BITS bits, LSB first; bit counter 0..DATA_BITS-1. After the last bit, go to PARITY if PARITY != 0, else to STOP.
  - PARITY: received parity bit p is compared against the data.
    - Even: error if XOR(data) ^ p = 1.
    - Odd: error if XOR(data) ^ p = 0.
    - Then go to STOP.
  - STOP: repeats STOP_BITS times. Any stop majority of 0 sets the pending frame error.
  - Commit: on the final stop bit at s = OVERSAMPLE/2+1, commit the frame and return to IDLE immediately (do not wait for the bit end), so the next start edge is resolved to 1/OVERSAMPLE bit.
- Commit, effective on the next clk edge:
  - If rx_valid = 0, or rx_valid && rx_ready in that same cycle: load rx_data, parity_err and frame_err, and set rx_valid = 1.
  - Otherwise: keep the old rx_data and flags, discard the new frame, and pulse overrun for 1 clk.
- rx_valid clears on the clk after rx_valid && rx_ready, unless a commit occurs in that same cycle, in which case it stays 1 with the new data.
- Frames with frame_err or parity_err are still delivered, with their flags set.
- The frame is not aborted on a low stop bit. The FSM still returns to IDLE. A line held low re-enters START after IDLE.
- busy = (state != IDLE), registered.
- Reset asserted mid-frame: everything returns to reset values immediately. A partial frame is never delivered.
- Width rules:
  - Shift register is DATA_BITS wide.
  - Counters are sized with $clog2 of their maximum.
  - Illegal parameter values (DATA_BITS outside 5..9, PARITY > 2, STOP_BITS outside 1..2, odd OVERSAMPLE) must trigger a simulation $error at elaboration.

Test Plan:
All tests use CLOCK_FREQ = 16_000_000, BAUD_RATE = 1_000_000 and OVERSAMPLE = 16, so TICK_DIV = 1 and 1 bit = 16 clk.
1. 8N1, send 0xA5 with rx_ready held 1. Also force rx high for 1 clk at the centre of bit 3 (a glitch). -> rx_data = 0xA5, rx_valid high for exactly 1 clk, parity_err = 0, frame_err = 0.
2. PARITY = 2, send 0x07 with parity bit 0. -> rx_data = 0x07, parity_err = 1. Then send 0x07 with parity bit 1. -> parity_err = 0.
3. 8N1, send 0x3C with the stop bit driven 0. -> rx_data = 0x3C, frame_err = 1. Then a following clean frame 0x55 -> frame_err = 0.
4. Drive rx low for 4 clk, then high. -> busy rises then falls within 1 bit time, no rx_valid, outputs unchanged.
5. rx_ready = 0, send 0x11 then 0x22 back-to-back. -> rx_data stays 0x11, overrun pulses for 1 clk at the 0x22 commit. Then raise rx_ready. -> 0x11 is accepted and rx_valid drops.
6. DATA_BITS = 9, STOP_BITS = 2, PARITY = 1. Assert rst during data bit 4, then send 0x1AB with correct parity. -> outputs read 0 while reset is asserted, then rx_data = 0x1AB with no errors.
